serial_addsub: RTL
==================

# serial_addsub

Parametrised bit-serial adder/subtractor, the successor to the fixed 16-bit serial adder in the DDCO datapath lab set.
- Generalises operand width and digit size (bits processed per cycle).
- Adds subtract mode, carry/borrow and signed-overflow flags, a busy indicator, and a registered result that never exposes partial sums.
- Sits between the operand registers and the result bus; it is driven by the same start/done handshake as the original adder.

## Interface
- WIDTH, 16, operand and result width in bits; must be at least 2.
- DIGIT, 1, bits added per clock; WIDTH must be an integer multiple of DIGIT.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (clk domain).
- start  input  1  one-cycle request; sampled only in IDLE or DONE.
- sub  input  1  0 selects A+B, 1 selects A−B; sampled with start.
- A  input  WIDTH  first operand; sampled with start.
- B  input  WIDTH  second operand; sampled with start.
- Sum  output  WIDTH  result register; updated only on completion.
- carry_out  output  1  carry out of the MSB; in subtract mode, 1 means no borrow.
- overflow  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse.

## Operation
- N = WIDTH/DIGIT digit steps per operation.
- States:
  - IDLE: waiting for start.
  - RUN: processing digits.
  - DONE: one cycle, done=1.
- Transitions:
  - IDLE → RUN on start=1.
  - RUN → DONE when digit counter reaches N−1.
  - DONE → RUN if start=1, else DONE → IDLE.
- Capture on accepted start:
  - opA ← A, opB ← (sub ? ~B : B).
  - Carry register ← sub.
  - Digit counter ← 0.
  - Internal result shift register cleared.
- Each RUN cycle:
  - Add the low DIGIT bits of opA, opB and the carry.
  - Shift the DIGIT-bit digit sum into the MSB end of the result shift register.
  - Shift opA/opB right by DIGIT and update the carry.
  - Record the carry into the MSB when processing the final digit, for the overflow calculation.
- On the RUN → DONE edge:
  - Sum ← completed shift register.
  - carry_out ← final carry.
  - overflow ← carry-into-MSB XOR final carry.
- Sum, carry_out and overflow hold their values until the next completion or reset. They are never updated mid-operation.
- start while in RUN is ignored; the operation in progress is not disturbed.
- A, B and sub may change freely after the capture edge.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - Sum=0, carry_out=0, overflow=0, busy=0, done=0.
  - Internal counter and operand registers are cleared.
- Reset mid-operation: the operation is aborted, and the previous Sum is not preserved.
- Release from reset is synchronous to clk. The first start is accepted on the first rising edge with reset=1.
- Latency:
  - Capture edge k puts the block in RUN; busy=1 from edge k.
  - Digits are processed on edges k+1 … k+N.
  - Edge k+N enters DONE: done=1, busy=0, and the new Sum is visible.
  - Example: WIDTH=16, DIGIT=1 gives done 16 cycles after the capture edge; DIGIT=4 gives 4 cycles.
- Throughput: with start asserted during the DONE cycle, one result every N+1 cycles. busy returns high on the next edge and done falls.
- done is exactly one cycle wide and never coincides with busy=1.

## Test plan
- Addition, WIDTH=16, DIGIT=1:
  - Stimulus: A=0x1234, B=0x5678, sub=0, one-cycle start.
  - Required: done exactly 16 edges after capture; Sum=0x68AC, carry_out=0, overflow=0.
  - Required: Sum keeps its previous value (0x0000 after reset) until done.
- Subtraction:
  - 0x0005−0x0007 → Sum=0xFFFE, carry_out=0 (borrow), overflow=0.
  - 0x8000−0x0001 → Sum=0x7FFF, carry_out=1, overflow=1.
- Flag boundaries:
  - 0x7FFF+0x0001 → Sum=0x8000, overflow=1, carry_out=0.
  - 0xFFFF+0x0001 → Sum=0x0000, carry_out=1, overflow=0.
- DIGIT=4 (and WIDTH=32, DIGIT=8) instances:
  - 0x1234+0x5678 → 0x68AC with done 4 edges after capture.
  - 32-bit: 0xFFFFFFFF+0x00000001 → Sum=0, carry_out=1, done 4 edges after capture.
- Handshake:
  - start re-asserted at cycle 5 of RUN with different A/B is ignored; the result matches the first operands.
  - start asserted in the DONE cycle starts the next operation immediately; its done follows N+1 cycles after the previous done.
- Reset mid-operation:
  - reset=0 at cycle 8 of RUN immediately clears busy, Sum and the flags.
  - After release, a new 0x0001+0x0001 completes with Sum=0x0002 and no residue from the aborted run.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, DIGIT bits per clock.
// Result and flags update only when the last digit completes.
module serial_addsub #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Sum,
   output logic             carry_out,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   generate
      if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad
         $error("serial_addsub: bad WIDTH/DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIN
   } state_t;

   state_t            state;
   logic [WIDTH-1:0]  opa;
   logic [WIDTH-1:0]  opb;
   logic [WIDTH-1:0]  acc;
   logic              cy;
   logic [CW-1:0]     cnt;

   logic [DIGIT:0]          dsum;
   logic [WIDTH+DIGIT-1:0]  cat;
   logic [WIDTH-1:0]        acc_n;
   logic                    cmsb;

   assign dsum  = {1'b0, opa[DIGIT-1:0]}
                + {1'b0, opb[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, cy};
   assign cat   = {dsum[DIGIT-1:0], acc};
   assign acc_n = cat[WIDTH+DIGIT-1:DIGIT];
   // carry into the top bit of the digit, recovered from its sum bit
   assign cmsb  = opa[DIGIT-1] ^ opb[DIGIT-1] ^ dsum[DIGIT-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         opa       <= '0;
         opb       <= '0;
         acc       <= '0;
         cy        <= 1'b0;
         cnt       <= '0;
         Sum       <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_RUN: begin
               opa <= opa >> DIGIT;
               opb <= opb >> DIGIT;
               cy  <= dsum[DIGIT];
               acc <= acc_n;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
                  state     <= S_FIN;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  Sum       <= acc_n;
                  carry_out <= dsum[DIGIT];
                  overflow  <= cmsb ^ dsum[DIGIT];
               end
            end
            default: begin
               if (start) begin
                  state <= S_RUN;
                  busy  <= 1'b1;
                  opa   <= A;
                  opb   <= sub ? ~B : B;
                  cy    <= sub;
                  cnt   <= '0;
                  acc   <= '0;
               end else begin
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule
